// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - raster timing bundle between timing generator and its consumers
//
// Purpose:
//   Carries the registered raster timing of one pixel from video_timing_gen to
//   downstream blocks (pattern generator, output encoder).
// Signals (all driven by the master, sampled by the slave):
//   hsync  1      horizontal sync, polarity set by the generator's H_POL
//   vsync  1      vertical sync, polarity set by the generator's V_POL
//   blank  1      1 outside the active region
//   de     1      data enable, always ~blank
//   x      CNT_W  horizontal position 0..H_TOTAL-1
//   y      CNT_W  vertical position 0..V_TOTAL-1
//   sol    1      one-cycle start-of-line strobe (x==0)
//   sof    1      one-cycle start-of-frame strobe (x==0 && y==0)
// Modports:
//   master  timing generator side (outputs)
//   slave   consumer side (inputs)
`timescale 1ns/1ps

interface video_timing_gen_if #(
   parameter int CNT_W = 12
) ();

   logic             hsync;
   logic             vsync;
   logic             blank;
   logic             de;
   logic [CNT_W-1:0] x;
   logic [CNT_W-1:0] y;
   logic             sol;
   logic             sof;

   modport master (
      output hsync,
      output vsync,
      output blank,
      output de,
      output x,
      output y,
      output sol,
      output sof
   );

   modport slave (
      input hsync,
      input vsync,
      input blank,
      input de,
      input x,
      input y,
      input sol,
      input sof
   );

endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator (hsync/vsync/blank/DE/x/y/sol/sof)
//
// Purpose:
//   Walks a raster of H_TOTAL x V_TOTAL pixels, one pixel per enabled clock,
//   and presents the syncs, blanking, coordinates and line/frame strobes of the
//   pixel it has just stepped onto. Each line and each frame is laid out as
//   active, front porch, sync, back porch.
// Ports:
//   i_clk    in      pixel clock
//   i_rst_n  in      asynchronous reset, active-low
//   i_en     in      pixel enable; the raster advances only when high
//   vid      master  registered timing outputs (see video_timing_gen_if)
`timescale 1ns/1ps

module video_timing_gen #(
   parameter int H_RES  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_RES  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33,
   parameter int H_POL  = 0,
   parameter int V_POL  = 0,
   parameter int CNT_W  = 12
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_en,
   video_timing_gen_if.master vid
);

   localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
   localparam longint CNT_SPAN = longint'(1) << CNT_W;

   // Configuration sanity: a zero-width segment or a counter that cannot reach
   // the last pixel/line would silently produce a broken raster.
   if (H_RES <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
       V_RES <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 || CNT_W <= 0) begin : g_bad_zero
      $error("video_timing_gen: timing parameters and CNT_W must be non-zero");
   end

   if (CNT_SPAN < longint'(H_TOTAL) || CNT_SPAN < longint'(V_TOTAL)) begin : g_bad_width
      $error("video_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
   end

   // Segment boundaries at counter width so every compare is width-matched.
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_RES);
   localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_RES);
   localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_RES + H_FP);
   localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_RES + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_RES + V_FP);
   localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_RES + V_FP + V_SYNC - 1);

   localparam logic H_ACT_LVL = 1'(H_POL);
   localparam logic V_ACT_LVL = 1'(V_POL);

   // ST_PRIME: coming out of reset, the first enabled edge must land on (0,0)
   // rather than step past it. ST_RUN: normal raster stepping.
   typedef enum logic {
      ST_PRIME = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic [CNT_W-1:0] h_nxt;
   logic [CNT_W-1:0] v_nxt;

   logic             act_nxt;
   logic             hs_nxt;
   logic             vs_nxt;
   logic             sol_nxt;
   logic             sof_nxt;

   logic             hsync_q;
   logic             vsync_q;
   logic             blank_q;
   logic             sol_q;
   logic             sof_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_PRIME;
      end else begin
         state_q <= state_d;
      end
   end

   // Next raster position; held when the pixel enable is low.
   always_comb begin
      state_d = state_q;
      h_nxt   = h_cnt;
      v_nxt   = v_cnt;
      if (i_en) begin
         case (state_q)
            ST_PRIME: begin
               h_nxt   = '0;
               v_nxt   = '0;
               state_d = ST_RUN;
            end
            ST_RUN: begin
               if (h_cnt == H_LAST) begin
                  h_nxt = '0;
                  v_nxt = (v_cnt == V_LAST) ? '0 : (v_cnt + ONE);
               end else begin
                  h_nxt = h_cnt + ONE;
               end
            end
            default: begin
               state_d = ST_PRIME;
            end
         endcase
      end
   end

   // Decode from the position about to be loaded, so the registered flags and
   // coordinates always describe the same pixel.
   always_comb begin
      act_nxt = (h_nxt < H_ACT_END) && (v_nxt < V_ACT_END);
      hs_nxt  = (h_nxt >= H_SYNC_LO) && (h_nxt <= H_SYNC_HI);
      vs_nxt  = (v_nxt >= V_SYNC_LO) && (v_nxt <= V_SYNC_HI);
      sol_nxt = (h_nxt == '0);
      sof_nxt = (h_nxt == '0) && (v_nxt == '0);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         h_cnt   <= '0;
         v_cnt   <= '0;
         hsync_q <= ~H_ACT_LVL;
         vsync_q <= ~V_ACT_LVL;
         blank_q <= 1'b1;
         sol_q   <= 1'b0;
         sof_q   <= 1'b0;
      end else begin
         // Strobes last one clock even if the enable then drops.
         sol_q <= 1'b0;
         sof_q <= 1'b0;
         if (i_en) begin
            h_cnt   <= h_nxt;
            v_cnt   <= v_nxt;
            hsync_q <= hs_nxt ? H_ACT_LVL : ~H_ACT_LVL;
            vsync_q <= vs_nxt ? V_ACT_LVL : ~V_ACT_LVL;
            blank_q <= ~act_nxt;
            sol_q   <= sol_nxt;
            sof_q   <= sof_nxt;
         end
      end
   end

   assign vid.hsync = hsync_q;
   assign vid.vsync = vsync_q;
   assign vid.blank = blank_q;
   assign vid.de    = ~blank_q;
   assign vid.x     = h_cnt;
   assign vid.y     = v_cnt;
   assign vid.sol   = sol_q;
   assign vid.sof   = sof_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed self-checking bench for video_timing_gen
//
// Purpose:
//   Two instances on a small 16x8 raster (H 8/2/3/3, V 4/1/2/1): dut_a with
//   active-low syncs, dut_b with active-high syncs, sharing clock, reset and enable.
`timescale 1ns/1ps

module tb_video_timing_gen;

   localparam int CW = 5;

   logic clk;
   logic rst_n;
   logic en;

   video_timing_gen_if #(.CNT_W(CW)) vif_a ();
   video_timing_gen_if #(.CNT_W(CW)) vif_b ();

   video_timing_gen #(
      .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_POL(0), .V_POL(0), .CNT_W(CW)
   ) dut_a (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_en    (en),
      .vid     (vif_a.master)
   );

   video_timing_gen #(
      .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_POL(1), .V_POL(1), .CNT_W(CW)
   ) dut_b (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_en    (en),
      .vid     (vif_b.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Bench model: linear pixel index within a 128-pixel frame.
   bit primed = 1'b0;
   bit pulse  = 1'b0;
   int mp     = 0;
   int cyc    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic check_all(input string ph);
      int  ex, ey;
      bit  hs_on, vs_on, e_de;
      ex    = primed ? (mp % 16) : 0;
      ey    = primed ? (mp / 16) : 0;
      e_de  = primed && (ex < 8) && (ey < 4);
      hs_on = primed && (ex >= 10) && (ex <= 12);
      vs_on = primed && (ey >= 5) && (ey <= 6);
      chk({ph, " x"},     32'(vif_a.x),     32'(ex));
      chk({ph, " y"},     32'(vif_a.y),     32'(ey));
      chk({ph, " de"},    32'(vif_a.de),    32'(e_de));
      chk({ph, " blank"}, 32'(vif_a.blank), 32'(!e_de));
      chk({ph, " hsync"}, 32'(vif_a.hsync), 32'(!hs_on));
      chk({ph, " vsync"}, 32'(vif_a.vsync), 32'(!vs_on));
      chk({ph, " sol"},   32'(vif_a.sol),   32'(pulse && ex == 0));
      chk({ph, " sof"},   32'(vif_a.sof),   32'(pulse && mp == 0));
      chk({ph, " hsync_pos"}, 32'(vif_b.hsync), 32'(hs_on));
      chk({ph, " vsync_pos"}, 32'(vif_b.vsync), 32'(vs_on));
   endtask

   // Called at a falling edge: drive enable, take one rising edge, check at the next falling edge.
   task automatic cycle(input bit e, input string ph);
      en = e;
      @(posedge clk);
      cyc++;
      if (e) begin
         if (!primed) begin
            primed = 1'b1;
            mp     = 0;
         end else begin
            mp = (mp + 1) % 128;
         end
         pulse = 1'b1;
      end else begin
         pulse = 1'b0;
      end
      @(negedge clk);
      check_all(ph);
   endtask

   task automatic sync_reset();
      rst_n  = 1'b0;
      primed = 1'b0;
      pulse  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_all("reset_hold");
      rst_n = 1'b1;
   endtask

   initial begin
      int  n_sof;
      int  n_vlow;
      int  last_sof;
      int  n_per;
      logic prev_vs;

      rst_n = 1'b0;
      en    = 1'b0;

      // Test 1: reset with clock running.
      repeat (3) @(negedge clk);
      check_all("t1_reset");

      // Tests 2/3: free-running enable for 300 clocks.
      rst_n   = 1'b1;
      n_sof   = 0;
      n_vlow  = 0;
      prev_vs = 1'b1;
      for (int i = 0; i < 300; i++) begin
         cycle(1'b1, "t2_run");
         if (vif_a.sof === 1'b1) n_sof++;
         if (vif_a.vsync === 1'b0) n_vlow++;
         if (prev_vs === 1'b1 && vif_a.vsync === 1'b0) begin
            chk("t3_vs_fall_sol", 32'(vif_a.sol), 32'd1);
            chk("t3_vs_fall_y",   32'(vif_a.y),   32'd5);
         end
         prev_vs = vif_a.vsync;
      end
      chk("t2_sof_count", 32'(n_sof),  32'd3);
      chk("t3_vsync_low", 32'(n_vlow), 32'd64);

      // Test 4: enable alternating 1/0 from a fresh reset.
      sync_reset();
      n_sof    = 0;
      n_per    = 0;
      last_sof = -1;
      for (int i = 0; i < 600; i++) begin
         cycle((i % 2) == 0, "t4_alt");
         if (vif_a.sof === 1'b1) begin
            n_sof++;
            if (last_sof >= 0) begin
               chk("t4_frame_period", 32'(cyc - last_sof), 32'd256);
               n_per++;
            end
            last_sof = cyc;
         end
      end
      chk("t4_sof_count", 32'(n_sof), 32'd3);
      chk("t4_periods",   32'(n_per), 32'd2);

      // Test 5: asynchronous reset at x=5, y=2.
      sync_reset();
      for (int i = 0; i < 38; i++) cycle(1'b1, "t5_run");
      chk("t5_pre_x", 32'(vif_a.x), 32'd5);
      chk("t5_pre_y", 32'(vif_a.y), 32'd2);
      #2;
      rst_n  = 1'b0;
      primed = 1'b0;
      pulse  = 1'b0;
      #1;
      check_all("t5_async_rst");
      @(negedge clk);
      check_all("t5_rst_low");
      rst_n = 1'b1;
      cycle(1'b1, "t5_first");
      chk("t5_first_sof", 32'(vif_a.sof), 32'd1);
      chk("t5_first_x",   32'(vif_a.x),   32'd0);
      chk("t5_first_y",   32'(vif_a.y),   32'd0);
      cycle(1'b1, "t5_second");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
